// File: rtl/duck_rom_arbiter.sv
// Round-robin arbiter letting two duck drawers share one synchronous sprite ROM.
// One fetch per clock; each response returns to its requester three cycles after acceptance.
module duck_rom_arbiter #(
  parameter int          IMG_W           = 96,
  parameter int          IMG_H           = 60,
  parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [6:0]  x0,
  input  logic [6:0]  x1,
  input  logic [5:0]  y0,
  input  logic [5:0]  y1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [11:0] rgb0,
  output logic [11:0] rgb1,
  output logic [12:0] rom_address,
  input  logic [11:0] rom_rgb
);

  localparam logic [12:0] W13 = 13'(IMG_W);
  localparam logic [12:0] H13 = 13'(IMG_H);

  typedef struct packed {
    logic valid;
    logic id;   // 1 = requester 1
    logic oor;  // out-of-range: answer with TRANSPARENT_RGB
  } tag_t;

  logic        last_id;
  logic        accept;
  logic        sel;
  logic [12:0] sel_x;
  logic [12:0] sel_y;
  logic        in_range;
  logic [12:0] addr_calc;
  tag_t        s1;
  tag_t        s2;

  // Grants are gated by rst_n so nothing is offered while reset is held.
  assign gnt0 = rst_n & req0 & (~req1 | last_id);
  assign gnt1 = rst_n & req1 & (~req0 | ~last_id);

  assign accept    = gnt0 | gnt1;
  assign sel       = gnt1;
  assign sel_x     = {6'd0, (sel ? x1 : x0)};
  assign sel_y     = {7'd0, (sel ? y1 : y0)};
  assign in_range  = (sel_x < W13) && (sel_y < H13);
  assign addr_calc = sel_y * W13 + sel_x;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id     <= 1'b1;
      rom_address <= '0;
      s1          <= '0;
      s2          <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rgb0        <= '0;
      rgb1        <= '0;
    end else begin
      if (accept) begin
        last_id     <= sel;
        rom_address <= in_range ? addr_calc : '0;
      end
      s1.valid <= accept;
      s1.id    <= sel;
      s1.oor   <= ~in_range;
      // s2 lines up with rom_rgb, which lags rom_address by one clock.
      s2       <= s1;
      rvalid0  <= s2.valid & ~s2.id;
      rvalid1  <= s2.valid &  s2.id;
      if (s2.valid && !s2.id) rgb0 <= s2.oor ? TRANSPARENT_RGB : rom_rgb;
      if (s2.valid &&  s2.id) rgb1 <= s2.oor ? TRANSPARENT_RGB : rom_rgb;
    end
  end

endmodule

// File: tb/tb_duck_rom_arbiter.sv
// Self-checking bench for duck_rom_arbiter: directed scenarios plus random traffic
// scored against a queue-based transaction model and a synchronous ROM model.
module tb_duck_rom_arbiter;

  localparam logic [11:0] TR = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [6:0]  x0 = '0, x1 = '0;
  logic [5:0]  y0 = '0, y1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [11:0] rgb0, rgb1, rom_rgb;
  logic [12:0] rom_address;

  duck_rom_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rgb0(rgb0), .rgb1(rgb1), .rom_address(rom_address), .rom_rgb(rom_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [12:0] a);
    logic [12:0] t;
    t = a * 13'd37 + 13'd11;
    return t[11:0] ^ 12'hA5C;
  endfunction

  always @(posedge clk) rom_rgb <= rom_f(rom_address);

  typedef struct {
    int          due;
    bit          id;
    bit          oor;
    logic [12:0] addr;
  } resp_t;

  resp_t       q[$];
  int          cyc = 0;
  int          last = 1;
  logic [12:0] exp_addr = '0;
  logic [11:0] exp_rgb0 = '0, exp_rgb1 = '0;
  int          n_checks = 0, n_fail = 0;

  logic        obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [11:0] obs_rgb0, obs_rgb1;
  logic [12:0] obs_addr;

  // One clock of traffic: drive, score every output against the model, then advance the model.
  task automatic cycle(input bit r0, input int xx0, input int yy0,
                       input bit r1, input int xx1, input int yy1);
    bit    m_g0, m_g1, e_rv0, e_rv1, id, oor;
    int    xs, ys;
    resp_t r;
    req0 = r0; x0 = 7'(xx0); y0 = 6'(yy0);
    req1 = r1; x1 = 7'(xx1); y1 = 6'(yy1);
    @(negedge clk);
    m_g0 = r0 && (!r1 || last == 1);
    m_g1 = r1 && (!r0 || last == 0);
    e_rv0 = 0; e_rv1 = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.id) begin e_rv1 = 1; exp_rgb1 = r.oor ? TR : rom_f(r.addr); end
      else      begin e_rv0 = 1; exp_rgb0 = r.oor ? TR : rom_f(r.addr); end
    end
    obs_g0 = gnt0; obs_g1 = gnt1; obs_rv0 = rvalid0; obs_rv1 = rvalid1;
    obs_rgb0 = rgb0; obs_rgb1 = rgb1; obs_addr = rom_address;
    n_checks += 7;
    if (gnt0 !== m_g0) begin n_fail++; $display("FAIL gnt0 cyc=%0d got=%b exp=%b", cyc, gnt0, m_g0); end
    if (gnt1 !== m_g1) begin n_fail++; $display("FAIL gnt1 cyc=%0d got=%b exp=%b", cyc, gnt1, m_g1); end
    if (rvalid0 !== e_rv0) begin n_fail++; $display("FAIL rvalid0 cyc=%0d got=%b exp=%b", cyc, rvalid0, e_rv0); end
    if (rvalid1 !== e_rv1) begin n_fail++; $display("FAIL rvalid1 cyc=%0d got=%b exp=%b", cyc, rvalid1, e_rv1); end
    if (rgb0 !== exp_rgb0) begin n_fail++; $display("FAIL rgb0 cyc=%0d got=%h exp=%h", cyc, rgb0, exp_rgb0); end
    if (rgb1 !== exp_rgb1) begin n_fail++; $display("FAIL rgb1 cyc=%0d got=%h exp=%h", cyc, rgb1, exp_rgb1); end
    if (rom_address !== exp_addr) begin n_fail++; $display("FAIL rom_address cyc=%0d got=%0d exp=%0d", cyc, rom_address, exp_addr); end
    @(posedge clk);
    if (m_g0 || m_g1) begin
      id  = m_g1;
      xs  = id ? xx1 : xx0;
      ys  = id ? yy1 : yy0;
      oor = !(xs < 96 && ys < 60);
      exp_addr = oor ? 13'd0 : 13'(ys * 96 + xs);
      q.push_back('{cyc + 3, id, oor, exp_addr});
      last = id ? 1 : 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset mid-cycle with both requests high and checks the asynchronous clear.
  task automatic apply_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    #1;
    n_checks += 8;
    if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid0 got=%b exp=0", rvalid0); end
    if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid1 got=%b exp=0", rvalid1); end
    if (rgb0 !== 12'h000) begin n_fail++; $display("FAIL rst_rgb0 got=%h exp=000", rgb0); end
    if (rgb1 !== 12'h000) begin n_fail++; $display("FAIL rst_rgb1 got=%h exp=000", rgb1); end
    if (rom_address !== 13'd0) begin n_fail++; $display("FAIL rst_rom_address got=%0d exp=0", rom_address); end
    if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0 got=%b exp=0", gnt0); end
    if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1 got=%b exp=0", gnt1); end
    if (^{rvalid0, rvalid1, rgb0, rgb1, rom_address} === 1'bx) begin
      n_fail++; $display("FAIL rst_unknown outputs contain X");
    end
    q.delete(); last = 1; exp_addr = '0; exp_rgb0 = '0; exp_rgb1 = '0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    idle(2);
  endtask

  task automatic test_single_fetch();
    cycle(1, 5, 2, 0, 0, 0);
    n_checks++;
    if (obs_g0 !== 1'b1 || obs_g1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt got=%b%b exp=10", obs_g0, obs_g1); end
    idle(1);
    n_checks++;
    if (obs_addr !== 13'd197) begin n_fail++; $display("FAIL single_addr got=%0d exp=197", obs_addr); end
    idle(2);
    n_checks++;
    if (obs_rv0 !== 1'b1 || obs_rgb0 !== rom_f(13'd197) || obs_rv1 !== 1'b0) begin
      n_fail++; $display("FAIL single_resp rv0=%b rgb0=%h rv1=%b exp 1 %h 0", obs_rv0, obs_rgb0, obs_rv1, rom_f(13'd197));
    end
  endtask

  task automatic test_contention();
    bit g[4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, i, i, 1, 10 + i, 20 + i);
      g[i] = obs_g1;
    end
    n_checks++;
    if ({g[0], g[1], g[2], g[3]} !== 4'b0101) begin
      n_fail++; $display("FAIL contention_order got=%b%b%b%b exp=0101", g[0], g[1], g[2], g[3]);
    end
    idle(4);
  endtask

  task automatic test_corner();
    cycle(0, 0, 0, 1, 95, 59);
    idle(1);
    n_checks++;
    if (obs_addr !== 13'd5759) begin n_fail++; $display("FAIL corner_addr got=%0d exp=5759", obs_addr); end
    idle(2);
    n_checks++;
    if (obs_rv1 !== 1'b1 || obs_rgb1 !== rom_f(13'd5759)) begin
      n_fail++; $display("FAIL corner_resp rv1=%b rgb1=%h exp 1 %h", obs_rv1, obs_rgb1, rom_f(13'd5759));
    end
  endtask

  task automatic test_out_of_range();
    cycle(1, 96, 0, 0, 0, 0);
    cycle(1, 0, 60, 0, 0, 0);
    n_checks++;
    if (obs_addr !== 13'd0) begin n_fail++; $display("FAIL oor_addr_a got=%0d exp=0", obs_addr); end
    idle(1);
    n_checks++;
    if (obs_addr !== 13'd0) begin n_fail++; $display("FAIL oor_addr_b got=%0d exp=0", obs_addr); end
    idle(1);
    n_checks++;
    if (obs_rv0 !== 1'b1 || obs_rgb0 !== TR) begin n_fail++; $display("FAIL oor_resp_a rv0=%b rgb0=%h exp 1 f0f", obs_rv0, obs_rgb0); end
    idle(1);
    n_checks++;
    if (obs_rv0 !== 1'b1 || obs_rgb0 !== TR) begin n_fail++; $display("FAIL oor_resp_b rv0=%b rgb0=%h exp 1 f0f", obs_rv0, obs_rgb0); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    cycle(1, 3, 4, 1, 7, 8);
    cycle(1, 9, 1, 1, 2, 2);
    cycle(1, 90, 50, 1, 1, 1);
    idle(1);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_rvalid rv=%b%b exp=00", obs_rv0, obs_rv1); end
    end
    cycle(1, 1, 1, 1, 2, 2);
    n_checks++;
    if (obs_g0 !== 1'b1) begin n_fail++; $display("FAIL post_reset_tie gnt0=%b exp=1", obs_g0); end
    idle(4);
  endtask

  task automatic test_pointer_hold();
    cycle(1, 4, 4, 0, 0, 0);
    idle(5);
    cycle(1, 6, 6, 1, 7, 7);
    n_checks++;
    if (obs_g1 !== 1'b1 || obs_g0 !== 1'b0) begin n_fail++; $display("FAIL pointer_hold gnt=%b%b exp=01", obs_g0, obs_g1); end
    idle(4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 127), $urandom_range(0, 63),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 127), $urandom_range(0, 63));
    idle(4);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_corner();
    test_out_of_range();
    test_reset_mid();
    test_pointer_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/duck_rom_arbiter.md
DUCK_ROM_ARBITER -- requirements
Module: duck_rom_arbiter

Interface
REQ-001 The block SHALL have parameter IMG_W, default 96, meaning sprite width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 60, meaning sprite height in pixels.
REQ-003 The block SHALL have parameter TRANSPARENT_RGB, default 12'hF0F, meaning the colour returned for out-of-range coordinates.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: port clk, input, 1 bit, the single rising-edge clock of all logic.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0 / req1  input  1 each  pixel fetch request from duck drawer 0 / 1.
REQ-007 x0 / x1  input  7 each  sprite column of the request.
REQ-008 y0 / y1  input  6 each  sprite row of the request.
REQ-009 gnt0 / gnt1  output  1 each  combinational grant; a request is accepted at the rising edge ending a cycle with reqN=1 and gntN=1.
REQ-010 rvalid0 / rvalid1  output  1 each  registered response strobe, one cycle wide per accepted request.
REQ-011 rgb0 / rgb1  output  12 each  registered response colour, {r,g,b} 4 bits each.
REQ-012 rom_address  output  13  registered address to the shared duck sprite ROM.
REQ-013 rom_rgb  input  12  ROM data, valid one clock after rom_address is presented.

Function
REQ-014 The arbiter SHALL accept at most one request per cycle, giving full throughput of one fetch per clock.
REQ-015 With exactly one reqN high, that requester SHALL be granted in the same cycle.
REQ-016 With both requests high, the requester other than the last accepted one SHALL be granted (round-robin).
REQ-017 The last-accepted pointer SHALL update only on an accepted request; idle cycles SHALL leave it unchanged.
REQ-018 With no request, gnt0=gnt1=0 and no transaction SHALL enter the pipeline.
REQ-019 For an accepted in-range request (x<IMG_W, y<IMG_H), the address SHALL be y*IMG_W+x, computed at 13-bit width without truncation (maximum 5759).
REQ-020 For an accepted out-of-range request, rom_address SHALL be driven to 0, and the response SHALL carry TRANSPARENT_RGB instead of rom_rgb.
REQ-021 Pipeline timing for a request accepted at the end of cycle C:
- rom_address valid in C+1.
- rom_rgb sampled at the end of C+2.
- rvalidN=1 and rgbN valid in C+3 only.
REQ-022 A response SHALL be returned only to the requester that issued it; the other rvalid SHALL stay 0 in that cycle.
REQ-023 Responses SHALL be delivered in acceptance order, with no loss for back-to-back accepted requests from either or both requesters.
REQ-024 rom_address SHALL hold its last value when no request is accepted.
REQ-025 rgbN SHALL hold its last value when rvalidN=0.
REQ-026 Requesters MAY change x/y or drop req in any cycle; only the values present in the accepting cycle SHALL be used.

Reset
REQ-027 On rst_n=0, independent of clk, the block SHALL set:
- rvalid0 = rvalid1 = 0.
- rgb0 = rgb1 = 12'h000.
- rom_address = 0.
- all in-flight pipeline tags cleared.
- last-accepted pointer = requester 1, so requester 0 wins the first tie.
REQ-028 Requests in flight when reset asserts SHALL produce no response after reset releases.
REQ-029 During reset, gnt0 and gnt1 SHALL be 0.

Verification
REQ-030 Single fetch: req0=1, x0=5, y0=2 for one cycle C -> gnt0=1 in C; rom_address=197 in C+1; rvalid0=1 with rgb0=ROM[197] in C+3; rvalid1=0 throughout.
REQ-031 Contention: req0=req1=1 held for 4 cycles after reset -> grants alternate 0,1,0,1; four responses return in that order, each 3 cycles after its grant.
REQ-032 Corner address: req1=1, x1=95, y1=59 -> rom_address=5759; rvalid1 with ROM[5759] three cycles later.
REQ-033 Out of range: req0=1, x0=96, y0=0, then x0=0, y0=60 -> rom_address=0 for both; rvalid0 with rgb0=12'hF0F for both.
REQ-034 Reset mid-operation: accept 3 back-to-back requests, assert rst_n=0 one cycle after the last -> outputs clear immediately; no rvalid after release; first tie after release grants requester 0.
REQ-035 Pointer hold: grant requester 0, idle 5 cycles, then req0=req1=1 -> requester 1 granted.
